// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared state encoding and widths for mul_arbiter.
// Imported by mul_arbiter and rr_arbiter.
package mul_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int MUL_OP_W    = 32;
   localparam int MUL_RES_W   = 64;
   localparam int TIMEOUT_DEF = 40;

endpackage

// File: rtl/mul_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// Produces a one-hot grant, its index and a found flag.
module rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             found
);

   // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (i >= int'(ptr))) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            gnt_id = ID_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            gnt_id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end sharing one iterative 32x32 multiplier.
// Define MUL_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles with resp_err.
module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ID_W    = 1,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [MUL_OP_W*N_REQ-1:0] req_a,
   input  logic [MUL_OP_W*N_REQ-1:0] req_b,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [MUL_RES_W-1:0]      resp_r,
   output logic                      resp_err,
   output logic                      mul_valid_in,
   output logic [MUL_OP_W-1:0]       mul_a,
   output logic [MUL_OP_W-1:0]       mul_b,
   input  logic                      mul_valid_out,
   input  logic [MUL_RES_W-1:0]      mul_r
);

   state_e               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [MUL_OP_W-1:0]  a_q, a_d;
   logic [MUL_OP_W-1:0]  b_q, b_d;
   logic                 busy1_q, busy1_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]      resp_id_q, resp_id_d;
   logic [MUL_RES_W-1:0] resp_r_q, resp_r_d;
   logic                 resp_err_q, resp_err_d;
   logic [N_REQ-1:0]     gnt;
   logic [ID_W-1:0]      gnt_id;
   logic                 found;
   logic                 mul_done;
   logic                 to_hit;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .found  (found)
   );

   // The first BUSY cycle may still see the previous op's valid_out.
   assign mul_done = (state_q == BUSY) && !busy1_q && mul_valid_out;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign to_hit = (state_q == BUSY) && !mul_done &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = ISSUE;
         ISSUE:   state_d = BUSY;
         BUSY:    if (mul_done || to_hit) state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      busy1_d      = (state_q == ISSUE);
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_r_d     = resp_r_q;
      resp_err_d   = resp_err_q;
      if (state_q == IDLE && found) begin
         id_d     = gnt_id;
         rr_ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
               a_d = req_a[i*MUL_OP_W +: MUL_OP_W];
               b_d = req_b[i*MUL_OP_W +: MUL_OP_W];
            end
         end
      end
      if (mul_done) begin
         resp_valid_d = 1'b1;
         resp_id_d    = id_q;
         resp_r_d     = mul_r;
         resp_err_d   = 1'b0;
      end else if (to_hit) begin
         resp_valid_d = 1'b1;
         resp_id_d    = id_q;
         resp_r_d     = '0;
         resp_err_d   = 1'b1;
      end
      if (state_q == RESP && resp_ready) begin
         resp_valid_d = 1'b0;
         resp_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         busy1_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_r_q     <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         busy1_q      <= busy1_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_r_q     <= resp_r_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Grants are suppressed while reset is held so nothing handshakes.
   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && !reset) req_ready = gnt;
      mul_valid_in = (state_q == ISSUE);
      mul_a        = a_q;
      mul_b        = b_q;
      resp_valid   = resp_valid_q;
      resp_id      = resp_id_q;
      resp_r       = resp_r_q;
      resp_err     = resp_err_q;
   end

endmodule
